alkmdseq: RTL and testbench

Multiply/divide step sequencer for the DC615 ALK. Launches a multiply or divide loop of 1–32 steps and counts the iterations. Drives the loop flag and the ALPCTL multiply/divide-group controls that steer the Q shift-in selection, and requests a one-cycle restoring fixup when a divide ends with a negative partial remainder. Sits between the ALPCTL field decode and the ALK Q/ALU shift-in routing, advancing once per unstalled microcycle.

---
 rtl/alkmdseq.sv | 97 +++++++++
 tb/tb_alkmdseq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alkmdseq.sv
// Multiply/divide step sequencer for the DC615 ALK: counts 1-32 loop steps and
// drives the loop flag, ALPCTL mul/div group controls and the divide fixup request.
module alkmdseq (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       mul_start_h,
    input  logic       div_start_h,
    input  logic [4:0] step_cnt_h,
    input  logic       stall_h,
    input  logic       abort_h,
    input  logic       c32_in_h,
    output logic       loopf_h,
    output logic       alpctl_mul_l,
    output logic       alpctl_mul_group_h,
    output logic       busy_h,
    output logic       fixup_h,
    output logic       done_h,
    output logic [4:0] remaining_h
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // Abort outranks stall; the counter is left alone on abort so software can inspect it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort_h) begin
            state_d = IDLE;
        end else if (!stall_h) begin
            case (state_q)
                IDLE: begin
                    if (mul_start_h) begin
                        state_d = MUL;
                        cnt_d   = step_cnt_h;
                    end else if (div_start_h) begin
                        state_d = DIV;
                        cnt_d   = step_cnt_h;
                    end
                end
                MUL: begin
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
                DIV: begin
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else if (c32_in_h) begin
                        state_d = DONE;
                    end else begin
                        state_d = FIX;
                    end
                end
                FIX:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered alongside the state so they are glitch-free Moore decodes.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q            <= IDLE;
            cnt_q              <= 5'd0;
            loopf_h            <= 1'b0;
            alpctl_mul_l       <= 1'b1;
            alpctl_mul_group_h <= 1'b0;
            busy_h             <= 1'b0;
            fixup_h            <= 1'b0;
            done_h             <= 1'b0;
            remaining_h        <= 5'd0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            loopf_h            <= (state_d == MUL) && (cnt_d != 5'd0);
            alpctl_mul_l       <= (state_d != MUL);
            alpctl_mul_group_h <= (state_d == DIV) || (state_d == FIX);
            busy_h             <= (state_d != IDLE);
            fixup_h            <= (state_d == FIX);
            done_h             <= (state_d == DONE);
            remaining_h        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alkmdseq.sv
// Directed testbench for alkmdseq: expected output vectors are queued as each
// stimulus step is driven and popped for comparison once the clock edge has passed.
module tb_alkmdseq;

    logic       clk;
    logic       reset_l;
    logic       mul_start_h;
    logic       div_start_h;
    logic [4:0] step_cnt_h;
    logic       stall_h;
    logic       abort_h;
    logic       c32_in_h;
    logic       loopf_h;
    logic       alpctl_mul_l;
    logic       alpctl_mul_group_h;
    logic       busy_h;
    logic       fixup_h;
    logic       done_h;
    logic [4:0] remaining_h;

    int checks = 0;
    int errors = 0;

    // Vector layout: {loopf, alpctl_mul_l, mul_group, busy, fixup, done, remaining[4:0]}
    logic [10:0] expQ[$];

    alkmdseq dut (
        .clk               (clk),
        .reset_l           (reset_l),
        .mul_start_h       (mul_start_h),
        .div_start_h       (div_start_h),
        .step_cnt_h        (step_cnt_h),
        .stall_h           (stall_h),
        .abort_h           (abort_h),
        .c32_in_h          (c32_in_h),
        .loopf_h           (loopf_h),
        .alpctl_mul_l      (alpctl_mul_l),
        .alpctl_mul_group_h(alpctl_mul_group_h),
        .busy_h            (busy_h),
        .fixup_h           (fixup_h),
        .done_h            (done_h),
        .remaining_h       (remaining_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] eIdle(input logic [4:0] rem);
        return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rem};
    endfunction

    function automatic logic [10:0] eMul(input logic loopf, input logic [4:0] rem);
        return {loopf, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rem};
    endfunction

    function automatic logic [10:0] eDiv(input logic [4:0] rem);
        return {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rem};
    endfunction

    function automatic logic [10:0] eFix();
        return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
    endfunction

    function automatic logic [10:0] eDone();
        return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
    endfunction

    task automatic checkOutput(input string tag);
        logic [10:0] observed;
        logic [10:0] expected;
        observed = {loopf_h, alpctl_mul_l, alpctl_mul_group_h, busy_h, fixup_h, done_h, remaining_h};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: observed %h required a queued expectation", tag, observed);
        end else begin
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    // Drives one microcycle of inputs, queues the outputs expected after the edge, then checks.
    task automatic applyStimulus(input string tag, input logic ms, input logic ds,
                                 input logic [4:0] cnt, input logic st, input logic ab,
                                 input logic c32, input logic [10:0] expv);
        mul_start_h = ms;
        div_start_h = ds;
        step_cnt_h  = cnt;
        stall_h     = st;
        abort_h     = ab;
        c32_in_h    = c32;
        expQ.push_back(expv);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkNow(input string tag, input logic [10:0] expv);
        expQ.push_back(expv);
        checkOutput(tag);
    endtask

    initial begin
        reset_l     = 1'b0;
        mul_start_h = 1'b0;
        div_start_h = 1'b0;
        step_cnt_h  = 5'd0;
        stall_h     = 1'b0;
        abort_h     = 1'b0;
        c32_in_h    = 1'b0;
        @(posedge clk);
        #1;
        checkNow("reset", eIdle(5'd0));
        @(posedge clk);
        #1;
        reset_l = 1'b1;

        $display("[TB] multiply n=3, div_start ignored while busy");
        applyStimulus("mul3_start", 1, 0, 5'd3, 0, 0, 0, eMul(1, 5'd3));
        applyStimulus("mul3_r2",    0, 1, 5'd9, 0, 0, 0, eMul(1, 5'd2));
        applyStimulus("mul3_r1",    0, 1, 5'd9, 0, 0, 0, eMul(1, 5'd1));
        applyStimulus("mul3_r0",    0, 0, 5'd0, 0, 0, 0, eMul(0, 5'd0));
        applyStimulus("mul3_done",  0, 0, 5'd0, 0, 0, 0, eDone());
        applyStimulus("mul3_idle",  0, 0, 5'd0, 0, 0, 0, eIdle(5'd0));

        $display("[TB] divide n=31, terminal carry 0");
        applyStimulus("div31c0_start", 0, 1, 5'd31, 0, 0, 1, eDiv(5'd31));
        for (int i = 30; i >= 0; i--)
            applyStimulus("div31c0_step", 0, 0, 5'd0, 0, 0, 1, eDiv(5'(i)));
        applyStimulus("div31c0_fix",  0, 0, 5'd0, 0, 0, 0, eFix());
        applyStimulus("div31c0_done", 0, 0, 5'd0, 0, 0, 0, eDone());
        applyStimulus("div31c0_idle", 0, 0, 5'd0, 0, 0, 0, eIdle(5'd0));

        $display("[TB] divide n=31, terminal carry 1");
        applyStimulus("div31c1_start", 0, 1, 5'd31, 0, 0, 0, eDiv(5'd31));
        for (int i = 30; i >= 0; i--)
            applyStimulus("div31c1_step", 0, 0, 5'd0, 0, 0, 0, eDiv(5'(i)));
        applyStimulus("div31c1_done", 0, 0, 5'd0, 0, 0, 1, eDone());
        applyStimulus("div31c1_idle", 0, 0, 5'd0, 0, 0, 0, eIdle(5'd0));

        $display("[TB] multiply n=2 with three stalled cycles");
        applyStimulus("mulst_start", 1, 0, 5'd2, 0, 0, 0, eMul(1, 5'd2));
        applyStimulus("mulst_r1",    0, 0, 5'd0, 0, 0, 0, eMul(1, 5'd1));
        for (int i = 0; i < 3; i++)
            applyStimulus("mulst_stall", 0, 0, 5'd0, 1, 0, 0, eMul(1, 5'd1));
        applyStimulus("mulst_r0",    0, 0, 5'd0, 0, 0, 0, eMul(0, 5'd0));
        applyStimulus("mulst_done",  0, 0, 5'd0, 0, 0, 0, eDone());
        applyStimulus("mulst_idle",  0, 0, 5'd0, 0, 0, 0, eIdle(5'd0));

        $display("[TB] simultaneous starts n=0, starts in DONE ignored, stalled DONE");
        applyStimulus("both_start",   1, 1, 5'd0, 0, 0, 0, eMul(0, 5'd0));
        applyStimulus("both_done",    0, 1, 5'd4, 0, 0, 0, eDone());
        applyStimulus("both_dstall",  1, 1, 5'd4, 1, 0, 0, eDone());
        applyStimulus("both_idle",    0, 1, 5'd4, 0, 0, 0, eIdle(5'd0));
        applyStimulus("both_hold",    0, 0, 5'd4, 0, 0, 0, eIdle(5'd0));

        $display("[TB] abort at remaining 5 in DIV, with stall asserted");
        applyStimulus("abort_start", 0, 1, 5'd7, 0, 0, 0, eDiv(5'd7));
        applyStimulus("abort_r6",    0, 0, 5'd0, 0, 0, 0, eDiv(5'd6));
        applyStimulus("abort_r5",    0, 0, 5'd0, 0, 0, 0, eDiv(5'd5));
        applyStimulus("abort_hit",   0, 0, 5'd0, 1, 1, 0, eIdle(5'd5));
        applyStimulus("abort_hold",  0, 0, 5'd0, 0, 0, 0, eIdle(5'd5));

        $display("[TB] divide n=0, carry ignored while stalled on terminal step");
        applyStimulus("div0_start", 0, 1, 5'd0, 0, 0, 0, eDiv(5'd0));
        applyStimulus("div0_stall", 0, 0, 5'd0, 1, 0, 0, eDiv(5'd0));
        applyStimulus("div0_done",  0, 0, 5'd0, 0, 0, 1, eDone());
        applyStimulus("div0_idle",  0, 0, 5'd0, 0, 0, 0, eIdle(5'd0));

        $display("[TB] asynchronous reset mid-multiply");
        applyStimulus("rst_start", 1, 0, 5'd9, 0, 0, 0, eMul(1, 5'd9));
        applyStimulus("rst_r8",    0, 0, 5'd0, 0, 0, 0, eMul(1, 5'd8));
        #2;
        reset_l = 1'b0;
        #1;
        checkNow("rst_async", eIdle(5'd0));
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        applyStimulus("rst_resume", 0, 0, 5'd0, 0, 0, 0, eIdle(5'd0));
        applyStimulus("rst_mul1",   1, 0, 5'd1, 0, 0, 0, eMul(1, 5'd1));
        applyStimulus("rst_mul0",   0, 0, 5'd0, 0, 0, 0, eMul(0, 5'd0));
        applyStimulus("rst_done",   0, 0, 5'd0, 0, 0, 0, eDone());
        applyStimulus("rst_idle",   0, 0, 5'd0, 0, 0, 0, eIdle(5'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
